// File: rtl/ser_to_par_deser.sv
// ser_to_par_deser
// ----------------
// Serial-to-parallel deserializer for the linear block code datapath.
// Each bit arriving on a rising clk16 edge with din_valid=1 is collected.
// Every WORD_W such bits form one parallel codeword.
// The completed word is handed to the decoder through a one-entry
// valid/ready holding register. A sticky flag reports any word that had
// to be dropped because that register was still occupied.
//
// Build option:
//   DESER_SOF_ALIGN_EN - when defined, sof (qualified by din_valid) forces
//                        the current bit to become bit 0 of a new word.
//                        Any partial word is discarded. When undefined,
//                        sof is ignored and words are counted modulo WORD_W.
//
// Parameters:
//   WORD_W    - bits per codeword (2..32), default 7 for Hamming(7,4)
//   MSB_FIRST - 1: first received bit lands in dout[WORD_W-1]
//               0: first received bit lands in dout[0]
//
// Ports:
//   clk16      in   bit clock, rising edge
//   rst        in   asynchronous active-high reset
//   din        in   serial data bit
//   din_valid  in   qualifies din (and sof) on this edge
//   sof        in   start-of-frame marker
//   dout       out  assembled codeword
//   dout_valid out  dout holds an unconsumed word
//   dout_ready in   consumer accepts dout on this edge
//   ovf        out  sticky: a completed word was dropped
//   ovf_clr    in   synchronous clear of ovf
//
// Handshake: a word moves to the consumer on a rising clk16 edge where
// dout_valid=1 and dout_ready=1. While dout_valid=1 and no transfer
// happens, dout holds its value. dout_ready is ignored while dout_valid=0.

module ser_to_par_deser #(
   parameter int WORD_W    = 7,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic              clk16,
   input  logic              rst,
   input  logic              din,
   input  logic              din_valid,
   input  logic              sof,
   output logic [WORD_W-1:0] dout,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic              ovf,
   input  logic              ovf_clr
);

   localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_W - 1);

   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  eff_cnt;
   logic [CNT_W-1:0]  pos;
   logic [WORD_W-1:0] sr;
   logic [WORD_W-1:0] word_next;
   logic              sof_start;
   logic              complete;
   logic              xfer;
   logic              drop;

`ifdef DESER_SOF_ALIGN_EN
   assign sof_start = din_valid & sof;
`else
   // sof has no effect in this build. It is still read so the port is not
   // left dangling.
   assign sof_start = 1'b0 & sof;
`endif

   // A start-of-frame marker makes the current bit count 0. This also
   // discards any partial word without raising an error.
   always_comb begin
      eff_cnt   = sof_start ? '0 : cnt;
      pos       = MSB_FIRST ? (LAST - eff_cnt) : eff_cnt;
      word_next = sr;
      word_next[pos] = din;
   end

   assign complete = din_valid & (eff_cnt == LAST);
   assign xfer     = dout_valid & dout_ready;
   assign drop     = complete & dout_valid & ~dout_ready;

   // The shift register is never cleared between words. Every position is
   // rewritten before the next completion, so stale bits cannot leak into
   // the next word.
   always_ff @(posedge clk16 or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         sr  <= '0;
      end else if (din_valid) begin
         sr  <= word_next;
         cnt <= complete ? '0 : eff_cnt + 1'b1;
      end
   end

   // Holding register. A completion edge with a transfer on the same edge
   // reloads without a bubble. A completion edge while the word is held
   // and not accepted loses the new word and sets ovf.
   always_ff @(posedge clk16 or posedge rst) begin
      if (rst) begin
         dout       <= '0;
         dout_valid <= 1'b0;
         ovf        <= 1'b0;
      end else begin
         if (complete && (!dout_valid || dout_ready)) begin
            dout       <= word_next;
            dout_valid <= 1'b1;
         end else if (xfer) begin
            dout_valid <= 1'b0;
         end
         // A drop on the same edge as ovf_clr takes priority.
         if (drop) begin
            ovf <= 1'b1;
         end else if (ovf_clr) begin
            ovf <= 1'b0;
         end
      end
   end

endmodule
